// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared fetch state encoding and PC defaults
package fetch_controller_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned     DEF_PC_INC   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-outstanding instruction fetch sequencer with redirect kill
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned     PC_INC   = DEF_PC_INC
) (
    input  logic            i_clock,
    input  logic            i_reset,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [XLEN-1:0] o_inst_code,
    output logic [XLEN-1:0] o_inst_pc
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;
    logic            r_inst_valid;
    logic [XLEN-1:0] r_inst_code;
    logic [XLEN-1:0] r_inst_pc;

    fetch_state_e    w_next_state;
    logic [XLEN-1:0] w_pc_next;
    logic            w_kill_next;
    logic            w_valid_next;
    logic            w_capture;
    logic            w_mem_req;
    logic [XLEN-1:0] w_redirect_tgt;

    assign w_redirect_tgt = word_align(i_redirect_pc);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst_code  <= '0;
            r_inst_pc    <= '0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_pc_next;
            r_kill       <= w_kill_next;
            r_inst_valid <= w_valid_next;
            if (w_capture) begin
                r_inst_code <= i_mem_rdata;
                r_inst_pc   <= r_pc;
            end
        end
    end

    // Redirect takes priority in every state; the granted-but-stale fetch is
    // tracked by r_kill so its response is swallowed in WAIT.
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_kill_next  = r_kill;
        w_valid_next = r_inst_valid;
        w_capture    = 1'b0;
        w_mem_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_REQ;
                if (i_redirect_valid) w_pc_next = w_redirect_tgt;
            end
            ST_REQ: begin
                w_mem_req = 1'b1;
                if (i_redirect_valid) begin
                    w_pc_next = w_redirect_tgt;
                    if (i_mem_gnt) begin
                        w_next_state = ST_WAIT;
                        w_kill_next  = 1'b1;
                    end
                end else if (i_mem_gnt) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_redirect_valid) begin
                    w_pc_next = w_redirect_tgt;
                    if (i_mem_rvalid) begin
                        w_next_state = ST_REQ;
                        w_kill_next  = 1'b0;
                    end else begin
                        w_kill_next  = 1'b1;
                    end
                end else if (i_mem_rvalid) begin
                    if (r_kill) begin
                        w_next_state = ST_REQ;
                        w_kill_next  = 1'b0;
                    end else begin
                        w_next_state = ST_HOLD;
                        w_capture    = 1'b1;
                        w_valid_next = 1'b1;
                        w_pc_next    = r_pc + XLEN'(PC_INC);
                    end
                end
            end
            ST_HOLD: begin
                if (i_redirect_valid) begin
                    w_pc_next    = w_redirect_tgt;
                    w_valid_next = 1'b0;
                    w_next_state = ST_REQ;
                end else if (i_inst_ready) begin
                    w_valid_next = 1'b0;
                    w_next_state = ST_REQ;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign o_mem_req    = w_mem_req;
    assign o_mem_addr   = r_pc;
    assign o_inst_valid = r_inst_valid;
    assign o_inst_code  = r_inst_code;
    assign o_inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst_code;
    logic [31:0] o_inst_pc;

    logic        reset2;
    logic        o_mem_req2;
    logic [31:0] o_mem_addr2;
    logic        i_mem_gnt2;
    logic        i_mem_rvalid2;
    logic        o_inst_valid2;
    logic [31:0] o_inst_code2;
    logic [31:0] o_inst_pc2;

    always #5 clk = ~clk;

    fetch_controller dut (
        .i_clock(clk), .i_reset(reset),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
        .o_inst_code(o_inst_code), .o_inst_pc(o_inst_pc)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(4)) dut2 (
        .i_clock(clk), .i_reset(reset2),
        .o_mem_req(o_mem_req2), .o_mem_addr(o_mem_addr2),
        .i_mem_gnt(i_mem_gnt2), .i_mem_rvalid(i_mem_rvalid2), .i_mem_rdata(32'hCAFE_0001),
        .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
        .o_inst_valid(o_inst_valid2), .i_inst_ready(1'b1),
        .o_inst_code(o_inst_code2), .o_inst_pc(o_inst_pc2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [63:0] sb[$];
    logic [31:0] exp_addr[$];
    int          hs_cyc[$];

    logic        pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat = 1;
    logic        gnt_last = 1'b0;
    logic        req2_last = 1'b0;
    logic [31:0] model_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic expect_fetch(input logic [31:0] pc);
        exp_addr.push_back(pc);
        sb.push_back({pc, mem_word(pc)});
    endtask

    task automatic sb_check();
        logic [63:0] e;
        if (o_inst_valid === 1'b1 && i_inst_ready === 1'b1) begin
            checks++;
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_spurious pc=%h code=%h expected no instruction", o_inst_pc, o_inst_code);
            end else begin
                e = sb.pop_front();
                if ({o_inst_pc, o_inst_code} !== e) begin
                    failures++;
                    $display("FAIL sb_inst pc=%h code=%h expected pc=%h code=%h",
                             o_inst_pc, o_inst_code, e[63:32], e[31:0]);
                end
            end
        end
    endtask

    // Memory model: one outstanding fetch, grants only addresses the test expects.
    task automatic mem_drive();
        logic [31:0] a;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            if (pend_cnt == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        gnt_last  = i_mem_gnt;
        i_mem_gnt = 1'b0;
        if (o_mem_req === 1'b1 && exp_addr.size() > 0 && !pend) begin
            a = exp_addr.pop_front();
            checks++;
            if (o_mem_addr !== a) begin
                failures++;
                $display("FAIL mem_addr got=%h expected=%h", o_mem_addr, a);
            end
            i_mem_gnt = 1'b1;
            pend      = 1'b1;
            pend_addr = o_mem_addr;
            pend_cnt  = lat - 1;
        end
        i_mem_rvalid2 = req2_last;
        req2_last     = (o_mem_req2 === 1'b1) && !reset2;
    endtask

    task automatic step();
        sb_check();
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    task automatic wait_sb_empty(input int budget, input string name);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d expected 0", name, sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({o_mem_req, o_mem_addr, o_inst_valid, o_inst_code, o_inst_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL %s req=%b addr=%h valid=%b code=%h pc=%h expected 0/0/0/0/0",
                     name, o_mem_req, o_mem_addr, o_inst_valid, o_inst_code, o_inst_pc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
        i_redirect_valid = 1'b0; i_redirect_pc = 32'h0; i_inst_ready = 1'b0;
        i_mem_gnt2 = 1'b1; i_mem_rvalid2 = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        lat = 1;
        i_inst_ready = 1'b1;
        hs_cyc.delete();
        for (int i = 0; i < 3; i++) expect_fetch(32'(i * 4));
        wait_sb_empty(40, "seq");
        for (int i = 1; i < 3 && i < hs_cyc.size(); i++) begin
            checks++;
            if (hs_cyc[i] - hs_cyc[i-1] != 3) begin
                failures++;
                $display("FAIL seq_spacing got=%0d expected=3", hs_cyc[i] - hs_cyc[i-1]);
            end
        end
        model_pc = 32'd12;
    endtask

    task automatic test_backpressure();
        logic [31:0] code_s, pc_s;
        int n = 0;
        i_inst_ready = 1'b0;
        expect_fetch(model_pc);
        while (o_inst_valid !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (o_inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_valid_timeout got=%b expected=1", o_inst_valid);
        end
        code_s = o_inst_code; pc_s = o_inst_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({o_inst_valid, o_inst_code, o_inst_pc, o_mem_req} !== {1'b1, code_s, pc_s, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold valid=%b code=%h pc=%h req=%b expected 1/%h/%h/0",
                         o_inst_valid, o_inst_code, o_inst_pc, o_mem_req, code_s, pc_s);
            end
        end
        expect_fetch(model_pc + 32'd4);
        i_inst_ready = 1'b1;
        wait_sb_empty(30, "bp");
        model_pc = model_pc + 32'd8;
    endtask

    task automatic test_redirect_wait();
        int n = 0;
        lat = 3;
        exp_addr.push_back(model_pc);
        expect_fetch(32'h0000_0100);
        while (!gnt_last && n < 20) begin step(); n++; end
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0100;
        step();
        i_redirect_valid = 1'b0;
        wait_sb_empty(30, "redir_wait");
        model_pc = 32'h0000_0104;
    endtask

    task automatic test_redirect_gnt();
        int n = 0;
        lat = 1;
        exp_addr.push_back(model_pc);
        expect_fetch(32'h0000_0200);
        while (i_mem_gnt !== 1'b1 && n < 20) begin step(); n++; end
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0203;
        step();
        i_redirect_valid = 1'b0;
        wait_sb_empty(30, "redir_gnt");
        model_pc = 32'h0000_0204;
    endtask

    task automatic test_wrap();
        int n = 0;
        reset2 = 1'b1;
        step(); step();
        checks++;
        if ({o_mem_req2, o_mem_addr2} !== {1'b0, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL wrap_reset req=%b addr=%h expected 0/fffffffc", o_mem_req2, o_mem_addr2);
        end
        reset2 = 1'b0;
        while (o_inst_valid2 !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if ({o_inst_valid2, o_inst_pc2, o_inst_code2} !== {1'b1, 32'hFFFF_FFFC, 32'hCAFE_0001}) begin
            failures++;
            $display("FAIL wrap_inst valid=%b pc=%h code=%h expected 1/fffffffc/cafe0001",
                     o_inst_valid2, o_inst_pc2, o_inst_code2);
        end
        n = 0;
        while (o_mem_req2 !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if ({o_mem_req2, o_mem_addr2} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL wrap_addr req=%b addr=%h expected 1/00000000", o_mem_req2, o_mem_addr2);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n = 0;
        lat = 2;
        exp_addr.push_back(model_pc);
        while (!gnt_last && n < 20) begin step(); n++; end
        reset = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset_mid_fetch");
        checks++;
        if (pend) begin
            failures++;
            $display("FAIL late_rvalid_not_delivered pend=%b expected 0", pend);
        end
        reset = 1'b0;
        expect_fetch(32'h0);
        wait_sb_empty(30, "post_reset");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
        test_reset_mid_fetch();
        repeat (4) step();
        checks++;
        if (exp_addr.size() != 0) begin
            failures++;
            $display("FAIL addr_queue_leftover got=%0d expected 0", exp_addr.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
